reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width; register count is 2**ADDR_W.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; `clk` and `reset` are the clock and reset port names.
REQ-004 Port `clk`: input, 1 bit, clock; all state updates on its rising edge.
REQ-005 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `RegWrite`: input, 1 bit, writeback enable.
REQ-007 Port `WriteRegister`: input, ADDR_W bits, writeback destination index, as selected by the RegDst mux.
REQ-008 Port `WriteData`: input, DATA_W bits, writeback data.
REQ-009 Port `ReadRegister1`: input, ADDR_W bits, read port 1 index (instruction bits 25:21).
REQ-010 Port `ReadRegister2`: input, ADDR_W bits, read port 2 index (instruction bits 20:16).
REQ-011 Port `ReadData1`: output, DATA_W bits, read port 1 data.
REQ-012 Port `ReadData2`: output, DATA_W bits, read port 2 data.
REQ-013 Port `LoadIssue`: input, 1 bit, a multicycle load is issuing this cycle.
REQ-014 Port `LoadDest`: input, ADDR_W bits, destination index of the issuing load.
REQ-015 Port `Stall`: output, 1 bit, a source register is pending; decode must hold.
REQ-016 Port `Busy`: output, 2**ADDR_W bits, scoreboard pending bit per register.

Function
REQ-017 Register 0 SHALL always read as 0, SHALL never be written, and SHALL never be marked busy.
REQ-018 On a rising edge with RegWrite=1 and WriteRegister!=0, regs[WriteRegister] SHALL take WriteData; the write is visible to reads from the next cycle.
REQ-019 ReadData1/ReadData2 SHALL be combinational: regs[ReadRegister1]/regs[ReadRegister2], zero-latency.
REQ-020 On a rising edge with LoadIssue=1 and LoadDest!=0, Busy[LoadDest] SHALL be set to 1.
REQ-021 On a rising edge with RegWrite=1 and WriteRegister!=0, Busy[WriteRegister] SHALL be cleared, unless the same register is set in that cycle.
REQ-022 When set and clear target the same register in one cycle, set SHALL win; the register stays busy for the new load.
REQ-023 When set and clear target different registers in one cycle, both updates SHALL take effect on the same edge.
REQ-024 Stall SHALL be combinational and equal (Busy[ReadRegister1] && ReadRegister1!=0) || (Busy[ReadRegister2] && ReadRegister2!=0).
REQ-025 Reissuing a load to an already-busy register SHALL leave that register busy, with no error and no count.
REQ-026 A writeback to a non-busy register SHALL write normally and leave Busy unchanged.

Reset
REQ-027 With reset=1 at a rising edge, all registers SHALL become 0 and Busy SHALL become all zeros; reset has priority over RegWrite and LoadIssue in that cycle.
REQ-028 After reset, ReadData1=ReadData2=0, Stall=0 and Busy=0 SHALL hold until the first write or load issue.
REQ-029 Reset asserted while loads are outstanding SHALL clear their busy bits; later writebacks to those registers SHALL be treated as ordinary writes.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL, when defined, add a write-to-read bypass: when RegWrite=1 and WriteRegister==ReadRegisterN!=0, ReadDataN SHALL equal WriteData in the same cycle.
REQ-031 With REGFILE_BYPASS_EN defined, Stall SHALL ignore a busy bit whose register is being written back in the current cycle.
REQ-032 Without REGFILE_BYPASS_EN, reads SHALL return only stored values, and Stall SHALL consider busy bits as registered, including those being cleared this cycle.

Verification
REQ-033 Reset, then read r0..r31 on both ports -> all 0, Stall=0, Busy=0.
REQ-034 Write r5=0xDEADBEEF, next cycle read r5 on port 1 -> 0xDEADBEEF; write r0=0x1234, read r0 -> 0.
REQ-035 LoadIssue with LoadDest=7, next cycle ReadRegister2=7 -> Stall=1 and Busy[7]=1; writeback r7=0x55 -> next cycle Stall=0 and ReadData2=0x55.
REQ-036 Same cycle: LoadIssue to r9 and writeback to r9 while r9 is busy -> Busy[9] stays 1; same cycle: LoadIssue to r3 and writeback to r4 (r4 busy) -> Busy[3]=1 and Busy[4]=0.
REQ-037 With REGFILE_BYPASS_EN: r8 busy, writeback r8=0xA5A5A5A5 while ReadRegister1=8 -> same cycle ReadData1=0xA5A5A5A5 and Stall=0; without the macro -> Stall=1 and the old value is read.
REQ-038 Busy r2 and r6, assert reset mid-operation -> next cycle Busy=0, Stall=0, all registers read 0.

Source files
------------

// File: rtl/reg_file_scoreboard_if.sv
// Register-file / load-scoreboard port bundle: writeback, two read ports,
// load issue and the scoreboard status outputs.
interface reg_file_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteRegister;
  logic [DATA_W-1:0]        WriteData;
  logic [ADDR_W-1:0]        ReadRegister1;
  logic [ADDR_W-1:0]        ReadRegister2;
  logic [DATA_W-1:0]        ReadData1;
  logic [DATA_W-1:0]        ReadData2;
  logic                     LoadIssue;
  logic [ADDR_W-1:0]        LoadDest;
  logic                     Stall;
  logic [(2**ADDR_W)-1:0]   Busy;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output LoadIssue, LoadDest,
    input  ReadData1, ReadData2, Stall, Busy
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  LoadIssue, LoadDest,
    output ReadData1, ReadData2, Stall, Busy
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Two-read/one-write register file with a per-register busy scoreboard for
// outstanding multicycle loads. Define REGFILE_BYPASS_EN for write-to-read bypass.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_file_scoreboard_if.slave   bus
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_wr_en;
  logic              w_ld_en;
  logic [DATA_W-1:0] w_rd1_stored;
  logic [DATA_W-1:0] w_rd2_stored;
  logic              w_hit1;
  logic              w_hit2;

  assign w_wr_en = bus.RegWrite  && (bus.WriteRegister != '0);
  assign w_ld_en = bus.LoadIssue && (bus.LoadDest      != '0);

  assign w_rd1_stored = (bus.ReadRegister1 == '0) ? '0 : r_regs[bus.ReadRegister1];
  assign w_rd2_stored = (bus.ReadRegister2 == '0) ? '0 : r_regs[bus.ReadRegister2];

  // A hit means the read index is being written back this very cycle.
`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = w_wr_en && (bus.WriteRegister == bus.ReadRegister1);
  assign w_hit2 = w_wr_en && (bus.WriteRegister == bus.ReadRegister2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  assign bus.ReadData1 = w_hit1 ? bus.WriteData : w_rd1_stored;
  assign bus.ReadData2 = w_hit2 ? bus.WriteData : w_rd2_stored;

  assign bus.Stall = (r_busy[bus.ReadRegister1] && (bus.ReadRegister1 != '0) && !w_hit1) ||
                     (r_busy[bus.ReadRegister2] && (bus.ReadRegister2 != '0) && !w_hit2);

  assign bus.Busy = r_busy;

  // Clear on writeback first so a same-register load issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en) w_busy_nxt[bus.WriteRegister] = 1'b0;
    if (w_ld_en) w_busy_nxt[bus.LoadDest]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_en) r_regs[bus.WriteRegister] <= bus.WriteData;
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: directed scenarios then random
// traffic, checked against an array-based reference model.
module tb_reg_file_scoreboard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  typedef struct {
    bit          chk;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [31:0] busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  reg_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] m_regs [NREG];
  logic [31:0] m_busy;
  bit          m_known;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, queue the expected outputs, advance the model past the edge.
  task automatic drive(input bit rst, input bit we, input int wreg, input logic [31:0] wdata,
                       input int rr1, input int rr2, input bit li, input int ld);
    exp_t e;
    bit   byp1;
    bit   byp2;
    @(negedge clk);
    reset                = rst;
    bus_if.RegWrite      = we;
    bus_if.WriteRegister = 5'(wreg);
    bus_if.WriteData     = wdata;
    bus_if.ReadRegister1 = 5'(rr1);
    bus_if.ReadRegister2 = 5'(rr2);
    bus_if.LoadIssue     = li;
    bus_if.LoadDest      = 5'(ld);
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    byp1 = we && (wreg != 0) && (wreg == rr1);
    byp2 = we && (wreg != 0) && (wreg == rr2);
`endif
    e.chk   = m_known;
    e.rd1   = byp1 ? wdata : ((rr1 == 0) ? 32'h0 : m_regs[rr1]);
    e.rd2   = byp2 ? wdata : ((rr2 == 0) ? 32'h0 : m_regs[rr2]);
    e.stall = (m_busy[rr1] && rr1 != 0 && !byp1) || (m_busy[rr2] && rr2 != 0 && !byp2);
    e.busy  = m_busy;
    sb_q.push_back(e);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_busy  = 32'h0;
      m_known = 1'b1;
    end else begin
      if (we && wreg != 0) begin
        m_regs[wreg] = wdata;
        m_busy[wreg] = 1'b0;
      end
      if (li && ld != 0) m_busy[ld] = 1'b1;
    end
  endtask

  task automatic idle(input int rr1, input int rr2);
    drive(1'b0, 1'b0, 0, 32'h0, rr1, rr2, 1'b0, 0);
  endtask

  function automatic int pick();
    return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  // Monitor: compares every settled output set against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          check("ReadData1", bus_if.ReadData1, mon_e.rd1);
          check("ReadData2", bus_if.ReadData2, mon_e.rd2);
          check("Stall", 32'(bus_if.Stall), 32'(mon_e.stall));
          check("Busy", bus_if.Busy, mon_e.busy);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_known  = 1'b0;
    m_busy   = 32'h0;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    reset = 1'b1;
    bus_if.RegWrite = 1'b0; bus_if.WriteRegister = '0; bus_if.WriteData = '0;
    bus_if.ReadRegister1 = '0; bus_if.ReadRegister2 = '0;
    bus_if.LoadIssue = 1'b0; bus_if.LoadDest = '0;

    drive(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
    drive(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 32; i++) idle(i, 31 - i);
    #2 check("post_reset_busy", bus_if.Busy, 32'h0);

    drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    idle(5, 0);
    #2 check("r5_read", bus_if.ReadData1, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 0, 32'h00001234, 0, 0, 1'b0, 0);
    idle(0, 0);
    #2 check("r0_read", bus_if.ReadData1, 32'h0);

    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 7);
    idle(0, 7);
    #2 check("r7_stall", 32'(bus_if.Stall), 32'd1);
    check("r7_busy", 32'(bus_if.Busy[7]), 32'd1);
    drive(1'b0, 1'b1, 7, 32'h55, 0, 7, 1'b0, 0);
    idle(0, 7);
    #2 check("r7_release_stall", 32'(bus_if.Stall), 32'd0);
    check("r7_data", bus_if.ReadData2, 32'h55);

    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 9);
    drive(1'b0, 1'b1, 9, 32'h99, 0, 0, 1'b1, 9);
    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 4);
    drive(1'b0, 1'b1, 4, 32'h44, 0, 0, 1'b1, 3);
    idle(0, 0);
    #2 check("r9_set_wins", 32'(bus_if.Busy[9]), 32'd1);
    check("r3_set", 32'(bus_if.Busy[3]), 32'd1);
    check("r4_clear", 32'(bus_if.Busy[4]), 32'd0);

    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 8);
    drive(1'b0, 1'b1, 8, 32'hA5A5A5A5, 8, 0, 1'b0, 0);
`ifdef REGFILE_BYPASS_EN
    #2 check("r8_bypass_data", bus_if.ReadData1, 32'hA5A5A5A5);
    check("r8_bypass_stall", 32'(bus_if.Stall), 32'd0);
`else
    #2 check("r8_old_data", bus_if.ReadData1, 32'h0);
    check("r8_stall", 32'(bus_if.Stall), 32'd1);
`endif

    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 2);
    drive(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 6);
    drive(1'b1, 1'b1, 3, 32'h33, 2, 6, 1'b1, 5);
    idle(2, 6);
    #2 check("reset_busy", bus_if.Busy, 32'h0);
    check("reset_stall", 32'(bus_if.Stall), 32'd0);
    check("reset_r3", bus_if.ReadData1 | bus_if.ReadData2, 32'h0);
    drive(1'b0, 1'b1, 2, 32'h22, 0, 0, 1'b0, 0);
    idle(2, 5);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) != 0), pick(), $urandom(),
            pick(), pick(), ($urandom_range(0, 9) < 3), pick());
    end
    idle(0, 0);
    @(negedge clk);
    #3 check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
